uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   NUM_REQ_DEF   : default number of byte-stream requesters
//   MAX_BURST_DEF : default maximum bytes forwarded per grant
//   GAP_W_DEF     : default width of the inter-burst gap counter
//   uart_arb_state_t : arbiter FSM state encoding
package uart_pkg;

  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 16;
  localparam int unsigned GAP_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
//   i_req : eligible request vector
//   i_ptr : index of the previous winner; search starts at i_ptr+1 with wrap
//   o_win : one-hot winner, all-zero when no request
//   o_any : at least one request present
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_win,
  output logic                       o_any
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic        found;
  logic [31:0] idx;

  // First requester found walking upward from i_ptr+1, modulo NUM_REQ.
  always_comb begin
    o_win = '0;
    o_any = |i_req;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(i_ptr) + off) % 32'(NUM_REQ);
      if (!found && i_req[PTR_W'(idx)]) begin
        o_win[PTR_W'(idx)] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter funnelling several byte streams into one UART transmitter.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_req_valid/_data/_last/_enable, o_req_ready : per-requester byte streams
//   i_gap_cycles          : idle cycles inserted after every released grant
//   o_tx_valid/_data, i_tx_ready : byte handshake towards the transmitter
//   o_tx_src, o_grant     : granted requester (index and one-hot)
//   o_busy                : arbiter is not idle
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned GAP_W     = GAP_W_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ-1:0][7:0]      i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  input  logic [NUM_REQ-1:0]           i_req_enable,
  input  logic [GAP_W-1:0]             i_gap_cycles,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic [7:0]                   o_tx_data,
  output logic [$clog2(NUM_REQ)-1:0]   o_tx_src,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  uart_arb_state_t    state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] pick_win;
  logic               pick_any;
  logic [SRC_W-1:0]   win_idx;
  logic               in_xfer;
  logic               xfer_fire;
  logic               rel_grant;
  logic [CNT_W-1:0]   burst_inc;

  // Only enabled requesters with a byte pending take part in arbitration.
  assign req_elig = i_req_valid & i_req_enable;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req (req_elig),
    .i_ptr (rr_ptr_q),
    .o_win (pick_win),
    .o_any (pick_any)
  );

  // One-hot to index for the registered source.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) begin
        win_idx = SRC_W'(i);
      end
    end
  end

  // Data path is a straight mux from the granted requester while in XFER.
  assign in_xfer     = (state_q == XFER);
  assign o_tx_valid  = in_xfer & i_req_valid[src_q];
  assign o_tx_data   = in_xfer ? i_req_data[src_q] : 8'd0;
  assign o_req_ready = in_xfer ? (grant_q & {NUM_REQ{i_tx_ready}}) : '0;
  assign o_grant     = grant_q;
  assign o_tx_src    = src_q;
  assign o_busy      = (state_q != IDLE);

  assign xfer_fire = o_tx_valid & i_tx_ready;
  assign burst_inc = burst_cnt_q + CNT_W'(1);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rel_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = XFER;
          grant_d     = pick_win;
          src_d       = win_idx;
          burst_cnt_d = '0;
        end
      end

      XFER: begin
        if (xfer_fire) begin
          burst_cnt_d = burst_inc;
          if (i_req_last[src_q] || (burst_inc == CNT_W'(MAX_BURST))) begin
            rel_grant = 1'b1;
          end
        end else if (!i_req_enable[src_q]) begin
          // Disabled owner with nothing in flight: drop the lock.
          rel_grant = 1'b1;
        end

        if (rel_grant) begin
          grant_d  = '0;
          rr_ptr_d = src_q;
          if (i_gap_cycles != '0) begin
            state_d   = GAP;
            gap_cnt_d = i_gap_cycles;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; rr_ptr resets to the last index so index 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      src_q       <= '0;
      rr_ptr_q    <= SRC_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      src_q       <= src_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule
